// File: rtl/mdu_sched_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
// Build with MDU_MULT_ITER_EN defined to use the iterative multiplier instead of the single-cycle one.
package mdu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int         MDU_ITER_CNT = 32;
    localparam logic [5:0] ITER_LAST    = 6'(MDU_ITER_CNT - 1);

    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_sched_div_core.sv
// Restoring radix-2 divider: 64-bit {remainder, quotient} shift register, one quotient bit per step.
module mdu_sched_div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [63:0] rq_q, rq_d;
    logic [31:0] divisor_q, divisor_d;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] quot_shift;

    // The shifted partial remainder is always below twice the divisor, so 33 bits suffice.
    always_comb begin
        rem_shift  = rq_q[63:31];
        quot_shift = {rq_q[30:0], 1'b0};
        diff       = rem_shift - {1'b0, divisor_q};
        rq_d       = rq_q;
        divisor_d  = divisor_q;
        if (load) begin
            rq_d      = {32'd0, dividend};
            divisor_d = divisor;
        end else if (step) begin
            if (!diff[32]) begin
                rq_d = {diff[31:0], quot_shift[31:1], 1'b1};
            end else begin
                rq_d = {rem_shift[31:0], quot_shift};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rq_q      <= 64'd0;
            divisor_q <= 32'd0;
        end else begin
            rq_q      <= rq_d;
            divisor_q <= divisor_d;
        end
    end

    assign quotient  = rq_q[31:0];
    assign remainder = rq_q[63:32];

endmodule

// File: rtl/mdu_sched.sv
// MULT/MULTU/DIV/DIVU scheduler owning architectural HI/LO; stalls EX while an op is in flight.
// MDU_MULT_ITER_EN selects the 32-cycle shift-add multiplier; otherwise multiply is single-cycle.
module mdu_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  mdu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    output logic        stallreq_for_ex,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    import mdu_sched_pkg::*;

    mdu_state_e  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        div0_q, div0_d;
    logic [31:0] src1_raw_q, src1_raw_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        sgn;
    logic [31:0] mag1, mag2;
    logic        div_load, div_step;
    logic [31:0] quot, rem;

`ifdef MDU_MULT_ITER_EN
    logic        is_div_q, is_div_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] acc_sum;
    logic [63:0] product;
`else
    logic [63:0] ext1, ext2, fast_prod;
`endif

    assign accept   = (state_q == ST_IDLE) && start && !flush;
    assign sgn      = op_is_signed(mdu_op);
    assign mag1     = magnitude(src1, sgn);
    assign mag2     = magnitude(src2, sgn);
    assign div_load = accept && op_is_div(mdu_op) && (src2 != 32'd0);
    assign div_step = (state_q == ST_DIV) && !flush;

    mdu_sched_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (quot),
        .remainder (rem)
    );

`ifdef MDU_MULT_ITER_EN
    assign acc_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign product = q_neg_q ? (~acc_q + 64'd1) : acc_q;
`else
    // Low 64 bits of the sign/zero-extended product equal the exact signed or unsigned result.
    assign ext1      = {{32{sgn & src1[31]}}, src1};
    assign ext2      = {{32{sgn & src2[31]}}, src2};
    assign fast_prod = ext1 * ext2;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        div0_d       = div0_q;
        src1_raw_d   = src1_raw_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        result_valid = 1'b0;
`ifdef MDU_MULT_ITER_EN
        is_div_d     = is_div_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    q_neg_d    = sgn & (src1[31] ^ src2[31]);
                    r_neg_d    = sgn & src1[31];
                    src1_raw_d = src1;
                    count_d    = 6'd0;
                    div0_d     = op_is_div(mdu_op) && (src2 == 32'd0);
`ifdef MDU_MULT_ITER_EN
                    is_div_d   = op_is_div(mdu_op);
                    mcand_d    = mag1;
                    acc_d      = {32'd0, mag2};
`endif
                    if (op_is_div(mdu_op)) begin
                        state_d = (src2 == 32'd0) ? ST_DONE : ST_DIV;
                    end else begin
`ifdef MDU_MULT_ITER_EN
                        state_d = ST_MUL;
`else
                        result_valid = 1'b1;
                        hi_d         = fast_prod[63:32];
                        lo_d         = fast_prod[31:0];
`endif
                    end
                end
            end
`ifdef MDU_MULT_ITER_EN
            ST_MUL: begin
                acc_d   = {acc_sum, acc_q[31:1]};
                count_d = count_q + 6'd1;
                if (count_q == ITER_LAST) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DIV: begin
                count_d = count_q + 6'd1;
                if (count_q == ITER_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
                if (div0_q) begin
                    lo_d = DIVZ_LO;
                    hi_d = src1_raw_q;
`ifdef MDU_MULT_ITER_EN
                end else if (!is_div_q) begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
`endif
                end else begin
                    lo_d = q_neg_q ? (~quot + 32'd1) : quot;
                    hi_d = r_neg_q ? (~rem + 32'd1) : rem;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // MTHI/MTLO only land in IDLE and lose to a same-cycle MDU commit.
        if ((state_q == ST_IDLE) && !result_valid) begin
            if (hi_we) hi_d = hilo_wdata;
            if (lo_we) lo_d = hilo_wdata;
        end

        if (flush) begin
            state_d      = ST_IDLE;
            count_d      = 6'd0;
            hi_d         = hi_q;
            lo_d         = lo_q;
            result_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= 6'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
            src1_raw_q <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
`ifdef MDU_MULT_ITER_EN
            is_div_q   <= 1'b0;
            mcand_q    <= 32'd0;
            acc_q      <= 64'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div0_q     <= div0_d;
            src1_raw_q <= src1_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
`ifdef MDU_MULT_ITER_EN
            is_div_q   <= is_div_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
`endif
        end
    end

`ifdef MDU_MULT_ITER_EN
    assign stallreq_for_ex = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
`else
    assign stallreq_for_ex = (accept && op_is_div(mdu_op)) || (state_q == ST_MUL) || (state_q == ST_DIV);
`endif

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed self-checking bench for mdu_sched with hand-computed HI/LO, latency and stall counts.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic [1:0]  mdu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        stallreq_for_ex;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MDU_MULT_ITER_EN
    localparam int MUL_RV    = 33;
    localparam int MUL_STALL = 33;
`else
    localparam int MUL_RV    = 0;
    localparam int MUL_STALL = 0;
`endif

    mdu_sched dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .start           (start),
        .mdu_op          (mdu_op),
        .src1            (src1),
        .src2            (src2),
        .hi_we           (hi_we),
        .lo_we           (lo_we),
        .hilo_wdata      (hilo_wdata),
        .stallreq_for_ex (stallreq_for_ex),
        .busy            (busy),
        .result_valid    (result_valid),
        .hi              (hi),
        .lo              (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        src1   = a;
        src2   = b;
    endtask

    // Issues one op and measures the result_valid cycle and number of stall cycles.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_rv, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int rv;
        int stalls;
        rv     = -1;
        stalls = 0;
        applyStimulus(op, a, b);
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stallreq_for_ex) stalls++;
            if (result_valid) begin
                rv = c;
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput({tag, "_rv_cycle"}, 64'(rv), 64'(exp_rv));
        checkOutput({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int rv;
        rst        = 1'b1;
        flush      = 1'b0;
        start      = 1'b0;
        mdu_op     = 2'b00;
        src1       = 32'd0;
        src2       = 32'd0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hilo_wdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_stall", 64'(stallreq_for_ex), 64'd0);
        checkOutput("reset_rv", 64'(result_valid), 64'd0);
        rst = 1'b0;

        @(negedge clk);
        hi_we      = 1'b1;
        hilo_wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we      = 1'b0;
        lo_we      = 1'b1;
        hilo_wdata = 32'h0000_5678;
        #1;
        checkOutput("mthi_hi", 64'(hi), 64'h1234);
        checkOutput("mthi_lo_untouched", 64'(lo), 64'd0);
        @(negedge clk);
        lo_we = 1'b0;
        #1;
        checkOutput("mtlo_lo", 64'(lo), 64'h5678);

        runOp("divu_100_7",  2'b11, 32'd100,       32'd7,         33, 33, 32'd2,         32'd14);
        runOp("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("div_min_m1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 33, 32'd0,         32'h8000_0000);
        runOp("div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 33, 33, 32'd1,         32'hFFFF_FFFD);
        runOp("divu_max_1",  2'b11, 32'hFFFF_FFFF, 32'd1,         33, 33, 32'd0,         32'hFFFF_FFFF);
        runOp("mult_m1_2",   2'b00, 32'hFFFF_FFFF, 32'd2,         MUL_RV, MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("multu_m1_2",  2'b01, 32'hFFFF_FFFF, 32'd2,         MUL_RV, MUL_STALL, 32'd1,         32'hFFFF_FFFE);
        runOp("mult_m3_m5",  2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, MUL_RV, MUL_STALL, 32'd0,         32'd15);
        runOp("divu_by0",    2'b11, 32'h1234_5678, 32'd0,         1,  1,  32'h1234_5678, 32'hFFFF_FFFF);

        // MTHI/MTLO asserted during DONE must lose to the divide result.
        rv = -1;
        applyStimulus(2'b11, 32'd100, 32'd7);
        for (int c = 0; c < 100; c++) begin
            #1;
            if (result_valid) begin
                rv = c;
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("collide_rv_cycle", 64'(rv), 64'd33);
        hi_we      = 1'b1;
        lo_we      = 1'b1;
        hilo_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("collide_hi", 64'(hi), 64'd2);
        checkOutput("collide_lo", 64'(lo), 64'd14);

        // Flush at iteration 10 of a divide: back to IDLE, HI/LO untouched.
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        checkOutput("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        checkOutput("flush_rv", 64'(result_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_stall", 64'(stallreq_for_ex), 64'd0);
        repeat (30) @(negedge clk);
        #1;
        checkOutput("flush_hi", 64'(hi), 64'd2);
        checkOutput("flush_lo", 64'(lo), 64'd14);

        // Reset in the middle of an iterative op.
`ifdef MDU_MULT_ITER_EN
        applyStimulus(2'b00, 32'd7, 32'd9);
`else
        applyStimulus(2'b11, 32'd100, 32'd7);
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_hi", 64'(hi), 64'd0);
        checkOutput("rst_mid_lo", 64'(lo), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_stall", 64'(stallreq_for_ex), 64'd0);

        runOp("after_rst_divu", 2'b11, 32'd1000, 32'd33, 33, 33, 32'd10, 32'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
